// File: rtl/flag_unit_if.sv
// flag_unit_if: EX-stage flag producer bus between the pipeline (master)
// and the flag unit (slave). Carries the EX instruction and ALU result in,
// and the flag register, branch flags, hazard and overflow count out.
interface flag_unit_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovfl;
  logic              stall;
  logic              flush;
  logic              ovf_cnt_clr;
  logic [2:0]        flags;
  logic [2:0]        flags_q;
  logic              flag_hazard;
  logic [CNT_W-1:0]  ovf_cnt;

  modport master (
    output ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, ovf_cnt_clr,
    input  flags, flags_q, flag_hazard, ovf_cnt
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, ovf_cnt_clr,
    output flags, flags_q, flag_hazard, ovf_cnt
  );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: derives N/V/Z from committed ALU results, holds the
// architectural flag register [N, V, Z], drives the branch-evaluator flags
// and decode hazard, and counts committed signed overflows (saturating).
// Optional feature macro: FLAG_BYPASS_EN (forward next-flag value onto
// flags while the EX instruction sets flags; hazard tied low).
module flag_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  flag_unit_if.slave   bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // ADD/SUB rewrite all three flags
  function automatic logic is_full_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Logic/shift ops only rewrite Z
  function automatic logic is_zonly_op(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [2:0]       nvz_q, nvz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       nvz_next;
  logic             full_op, zonly_op, sets, commit;
  logic             res_zero, res_neg;

  // Classify the EX instruction and form the candidate flag value
  always_comb begin
    full_op  = is_full_op(bus.ex_opcode);
    zonly_op = is_zonly_op(bus.ex_opcode);
    sets     = bus.ex_valid && !bus.flush && (full_op || zonly_op);
    commit   = sets && !bus.stall;
    res_zero = (bus.alu_result == '0);
    res_neg  = bus.alu_result[DATA_W-1];
    if (full_op) begin
      nvz_next = {res_neg, bus.alu_ovfl, res_zero};
    end else begin
      nvz_next = {nvz_q[2], nvz_q[1], res_zero};
    end
  end

  // Next state of the flag register and overflow counter
  always_comb begin
    nvz_d = nvz_q;
    cnt_d = cnt_q;
    if (commit) begin
      nvz_d = nvz_next;
    end
    if (bus.ovf_cnt_clr) begin
      cnt_d = '0;
    end else if (commit && full_op && bus.alu_ovfl) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nvz_q <= 3'b000;
      cnt_q <= '0;
    end else begin
      nvz_q <= nvz_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.flags_q = nvz_q;
  assign bus.ovf_cnt = cnt_q;

  // Outputs to decode: reset masks any EX instruction so both read idle
`ifdef FLAG_BYPASS_EN
  assign bus.flags       = (sets && !rst) ? nvz_next : nvz_q;
  assign bus.flag_hazard = 1'b0;
`else
  assign bus.flags       = nvz_q;
  assign bus.flag_hazard = sets && !rst;
`endif

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  flag_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifc ();

  flag_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mN, mV, mZ, mCnt;

  function automatic int op_class(input logic [3:0] op);
    // 2 = full update, 1 = Z only, 0 = none
    case (op)
      4'd0, 4'd1:             return 2;
      4'd2, 4'd4, 4'd5, 4'd6: return 1;
      default:                return 0;
    endcase
  endfunction

  function automatic logic m_sets();
    return ifc.ex_valid && !ifc.flush && (op_class(ifc.ex_opcode) != 0) && !rst;
  endfunction

  function automatic logic [2:0] m_next();
    int n, v, z;
    z = (ifc.alu_result == 0) ? 1 : 0;
    if (op_class(ifc.ex_opcode) == 2) begin
      n = ifc.alu_result[DATA_W-1] ? 1 : 0;
      v = ifc.alu_ovfl ? 1 : 0;
    end else begin
      n = mN;
      v = mV;
    end
    return {n[0], v[0], z[0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mN = 0; mV = 0; mZ = 0; mCnt = 0;
    end else begin
      logic commit;
      logic [2:0] nx;
      commit = m_sets() && !ifc.stall;
      nx = m_next();
      if (ifc.ovf_cnt_clr) mCnt = 0;
      else if (commit && op_class(ifc.ex_opcode) == 2 && ifc.alu_ovfl && mCnt < CNT_MAX)
        mCnt = mCnt + 1;
      if (commit) begin
        mN = nx[2]; mV = nx[1]; mZ = nx[0];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    logic [2:0] mq;
    mq = {mN[0], mV[0], mZ[0]};
    check("flags_q", int'(ifc.flags_q), int'(mq));
    check("ovf_cnt", int'(ifc.ovf_cnt), mCnt);
`ifdef FLAG_BYPASS_EN
    check("flags", int'(ifc.flags), int'(m_sets() ? m_next() : mq));
    check("flag_hazard", int'(ifc.flag_hazard), 0);
`else
    check("flags", int'(ifc.flags), int'(mq));
    check("flag_hazard", int'(ifc.flag_hazard), int'(m_sets()));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic fl, input logic clr);
    ifc.ex_valid    = v;
    ifc.ex_opcode   = op;
    ifc.alu_result  = res;
    ifc.alu_ovfl    = ov;
    ifc.stall       = st;
    ifc.flush       = fl;
    ifc.ovf_cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    // Reset held with a live ADD of zero in EX
    drive(1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_flags_q", int'(ifc.flags_q), 0);
    check("rst_ovf_cnt", int'(ifc.ovf_cnt), 0);
    check("rst_hazard", int'(ifc.flag_hazard), 0);
    rst = 1'b0;
    tick();
    check("post_rst_flags_q", int'(ifc.flags_q), 3'b001);

    // ADD 8000 with overflow, then XOR giving zero
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("add_ovf_flags_q", int'(ifc.flags_q), 3'b110);
    check("add_ovf_cnt", int'(ifc.ovf_cnt), 1);
    drive(1'b1, 4'h2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("xor_zero_flags_q", int'(ifc.flags_q), 3'b111);

    // SUB 5 stalled two cycles
    drive(1'b1, 4'h1, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
`ifdef FLAG_BYPASS_EN
      check("stall_flags_bypass", int'(ifc.flags), 3'b000);
`else
      check("stall_hazard", int'(ifc.flag_hazard), 1);
`endif
      tick();
      check("stall_flags_q_held", int'(ifc.flags_q), 3'b111);
    end
    ifc.stall = 1'b0;
    tick();
    check("sub_commit_flags_q", int'(ifc.flags_q), 3'b000);

    // Flushed ADD with overflow, then LW with zero result
    drive(1'b1, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("flush_hazard", int'(ifc.flag_hazard), 0);
    tick();
    check("flush_flags_q", int'(ifc.flags_q), 3'b000);
    check("flush_ovf_cnt", int'(ifc.ovf_cnt), 1);
    drive(1'b1, 4'h8, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("lw_flags_q", int'(ifc.flags_q), 3'b000);

    // Counter saturation, then clear beats increment
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'h0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("cnt_saturated", int'(ifc.ovf_cnt), 255);
    drive(1'b1, 4'h0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("cnt_clr_wins", int'(ifc.ovf_cnt), 0);

    // Single ADD in EX followed by idle: one-cycle hazard
    drive(1'b1, 4'h0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
`ifndef FLAG_BYPASS_EN
    check("haz_during_add", int'(ifc.flag_hazard), 1);
    check("flags_before_add", int'(ifc.flags), 3'b010);
`endif
    tick();
    idle();
    #1;
    check("haz_after_add", int'(ifc.flag_hazard), 0);
    check("flags_after_add", int'(ifc.flags), 3'b100);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [15:0] res;
      logic        r;
      r = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0, 1:    op = 4'($urandom_range(0, 1));
        2:       op = 4'($urandom_range(2, 6));
        default: op = 4'($urandom);
      endcase
      res = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      drive($urandom_range(0, 9) != 0, op, res, 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 19) == 0);
      rst = r;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
